// File: rtl/adder_pkg.sv
// Shared types for the carry-select adder operand path.
// Provides the loader FSM state type and the serial byte width.
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } loader_state_t;

endpackage

// File: rtl/operand_byte_loader_packer.sv
// byte_packer: byte-lane write register, one lane per load.
// Ports: clk, areset_n, clear, load, idx (lane), data (byte), q (word).
module byte_packer
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int NB = WIDTH / BYTE_W,
  localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [IW-1:0]     idx,
  input  logic [BYTE_W-1:0] data,
  output logic [WIDTH-1:0]  q
);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q[idx*BYTE_W +: BYTE_W] <= data;
    end
  end

endmodule

// File: rtl/operand_byte_loader.sv
// operand_byte_loader: assembles A then B (LSB first) from a byte stream
// and presents them to the adder over out_valid/out_ready.
// Ports: clk, areset_n, flush, in_byte/in_valid/in_ready (serial side),
// op_a/op_b/out_valid/out_ready (adder side), busy.
// Optional macro OPERAND_PARITY_EN adds in_parity and par_err.
module operand_byte_loader
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              flush,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef OPERAND_PARITY_EN
  input  logic              in_parity,
  output logic              par_err,
`endif
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  loader_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          wr_a, wr_b, clr;
  logic          xfer, last;

`ifdef OPERAND_PARITY_EN
  logic pair_bad, bad_nx, par_nx, byte_bad;
  assign byte_bad = ^{in_byte, in_parity};
`endif

  // Held low in reset so nothing is accepted before the FSM is live.
  assign in_ready  = areset_n & (state != PRESENT);
  assign out_valid = (state == PRESENT);
  assign busy      = (state != LOAD_A) | (cnt != '0);
  assign xfer      = in_valid & in_ready;
  assign last      = (cnt == LAST);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= LOAD_A;
      cnt   <= '0;
`ifdef OPERAND_PARITY_EN
      pair_bad <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef OPERAND_PARITY_EN
      pair_bad <= bad_nx;
      par_err  <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    clr      = 1'b0;
`ifdef OPERAND_PARITY_EN
    bad_nx   = pair_bad;
    par_nx   = 1'b0;
`endif
    if (flush) begin
      state_nx = LOAD_A;
      cnt_nx   = '0;
      clr      = 1'b1;
`ifdef OPERAND_PARITY_EN
      bad_nx   = 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD_A: begin
          if (xfer) begin
            wr_a = 1'b1;
`ifdef OPERAND_PARITY_EN
            bad_nx = pair_bad | byte_bad;
`endif
            if (last) begin
              cnt_nx   = '0;
              state_nx = LOAD_B;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            wr_b = 1'b1;
`ifdef OPERAND_PARITY_EN
            bad_nx = pair_bad | byte_bad;
`endif
            if (last) begin
              cnt_nx = '0;
`ifdef OPERAND_PARITY_EN
              if (pair_bad | byte_bad) begin
                state_nx = LOAD_A;
                par_nx   = 1'b1;
                bad_nx   = 1'b0;
              end else begin
                state_nx = PRESENT;
              end
`else
              state_nx = PRESENT;
`endif
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        PRESENT: begin
          if (out_ready) state_nx = LOAD_A;
        end
        default: state_nx = LOAD_A;
      endcase
    end
  end

  byte_packer #(.WIDTH(WIDTH)) u_pack_a (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (clr),
    .load     (wr_a),
    .idx      (cnt),
    .data     (in_byte),
    .q        (op_a)
  );

  byte_packer #(.WIDTH(WIDTH)) u_pack_b (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (clr),
    .load     (wr_b),
    .idx      (cnt),
    .data     (in_byte),
    .q        (op_b)
  );

endmodule

// File: tb/tb_operand_byte_loader.sv
// Self-checking bench for operand_byte_loader (32-bit build).
// Table-driven main flow plus directed gap/flush/reset/parity sequences.
module tb_operand_byte_loader;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        flush;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef OPERAND_PARITY_EN
  logic        in_parity;
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_byte_loader #(.WIDTH(32)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .flush     (flush),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef OPERAND_PARITY_EN
    .in_parity (in_parity),
    .par_err   (par_err),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic        bz;
    logic [31:0] a;
    logic [31:0] bb;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input logic bad);
    in_byte = b;
`ifdef OPERAND_PARITY_EN
    in_parity = (^b) ^ bad;
`else
    if (bad) $display("bad parity requested without parity build");
`endif
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    in_valid = 1'b1;
    drive(b, bad);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b0);
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " ov after accept"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ea, eb, wa, wb;
    int gap;

    tbl[0]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000078, 32'h0};
    tbl[1]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00005678, 32'h0};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00345678, 32'h0};
    tbl[3]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0};
    tbl[4]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h000000F0};
    tbl[5]  = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0000DEF0};
    tbl[6]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h00BCDEF0};
    tbl[7]  = '{1'b1, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[12] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0};
    tbl[13] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0};
    tbl[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345655, 32'h9ABCDEF0};
    tbl[15] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};

    areset_n  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(8'h00, 1'b0);

    #12;
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst op_a", op_a, 32'd0);
    chk("rst op_b", op_b, 32'd0);
    #1 areset_n = 1'b1;
    tick();
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // Tests 1 and 2: back-to-back load, stall, accept, reload, flush.
    for (int i = 0; i < 16; i++) begin
      in_valid  = tbl[i].v;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      drive(tbl[i].b, 1'b0);
      tick();
      chk($sformatf("tbl%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
      chk($sformatf("tbl%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
      chk($sformatf("tbl%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].bz});
      chk($sformatf("tbl%0d op_a", i), op_a, tbl[i].a);
      chk($sformatf("tbl%0d op_b", i), op_b, tbl[i].bb);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Test 3: idle gaps between bytes must not advance the lane.
    wa = 32'h12345678;
    wb = 32'h9ABCDEF0;
    ea = 32'h0;
    eb = 32'h0;
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        drive(8'($urandom_range(0, 255)), 1'b0);
        tick();
        chk($sformatf("gap%0d op_a", i), op_a, ea);
        chk($sformatf("gap%0d op_b", i), op_b, eb);
      end
      if (i < 4) begin
        send(wa[8*i +: 8], 1'b0);
        ea[8*i +: 8] = wa[8*i +: 8];
      end else begin
        send(wb[8*(i-4) +: 8], 1'b0);
        eb[8*(i-4) +: 8] = wb[8*(i-4) +: 8];
      end
      chk($sformatf("gapbyte%0d op_a", i), op_a, ea);
      chk($sformatf("gapbyte%0d op_b", i), op_b, eb);
    end
    chk("gap out_valid", {31'b0, out_valid}, 32'd1);
    handshake("gap");

    // Test 4: flush on the 3rd A byte, then flush during PRESENT.
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    drive(8'hC3, 1'b0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flushA op_a", op_a, 32'd0);
    chk("flushA busy", {31'b0, busy}, 32'd0);
    chk("flushA out_valid", {31'b0, out_valid}, 32'd0);
    send_word(32'h0BADF00D);
    send_word(32'h13579BDF);
    chk("flush reload op_a", op_a, 32'h0BADF00D);
    chk("flush reload op_b", op_b, 32'h13579BDF);
    chk("flush reload ov", {31'b0, out_valid}, 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flushP out_valid", {31'b0, out_valid}, 32'd0);
    chk("flushP op_a", op_a, 32'd0);
    chk("flushP op_b", op_b, 32'd0);
    chk("flushP busy", {31'b0, busy}, 32'd0);

    // Test 5: asynchronous reset glitch during LOAD_B.
    send_word(32'hDEADBEEF);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    #2 areset_n = 1'b0;
    #1;
    chk("glitch op_a", op_a, 32'd0);
    chk("glitch op_b", op_b, 32'd0);
    chk("glitch busy", {31'b0, busy}, 32'd0);
    chk("glitch in_ready", {31'b0, in_ready}, 32'd0);
    #2 areset_n = 1'b1;
    tick();
    send_word(32'hCAFEBABE);
    send_word(32'h01020304);
    chk("fresh op_a", op_a, 32'hCAFEBABE);
    chk("fresh op_b", op_b, 32'h01020304);
    chk("fresh ov", {31'b0, out_valid}, 32'd1);
    handshake("fresh");

`ifdef OPERAND_PARITY_EN
    // Test 6: bad parity on the 2nd A byte drops the pair.
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send_word(32'h55667788);
    chk("par out_valid", {31'b0, out_valid}, 32'd0);
    chk("par par_err", {31'b0, par_err}, 32'd1);
    chk("par busy", {31'b0, busy}, 32'd0);
    tick();
    chk("par pulse end", {31'b0, par_err}, 32'd0);
    send_word(32'hA5A5F00F);
    send_word(32'h5A5A0FF0);
    chk("par good ov", {31'b0, out_valid}, 32'd1);
    chk("par good err", {31'b0, par_err}, 32'd0);
    chk("par good op_a", op_a, 32'hA5A5F00F);
    chk("par good op_b", op_b, 32'h5A5A0FF0);
    handshake("par good");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
